// File: rtl/riscv_multicycle_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : riscv_multicycle_controller                              |
// | Description : Multi-cycle RV32I control FSM. Sequences fetch, decode,  |
// |               execute, memory and writeback over one shared memory    |
// |               port with a ready handshake and drives every datapath   |
// |               mux select and write strobe.                            |
// |               Optional macro RISC_ILLEGAL_TRAP_EN: an illegal opcode  |
// |               parks the FSM in TRAP with IllegalInstr=1 until reset;  |
// |               when undefined an illegal opcode retires as a NOP.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module riscv_multicycle_controller #(
  parameter int W        = 32,
  parameter int ALUCTL_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [W-1:0]        Instr,
  input  logic                Zero,
  input  logic                Negative,
  input  logic                Carry,
  input  logic                Overflow,
  input  logic                MemReady,
  output logic                MemReq,
  output logic                MemWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                InstrDone,
  output logic                IllegalInstr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_bit30;
  logic [2:0] w_imm_src;
  logic [3:0] w_alu_op;
  logic [3:0] w_alu;
  logic       w_taken;
  logic       w_unused;

  assign w_opcode = Instr[6:0];
  assign w_funct3 = Instr[14:12];
  assign w_bit30  = Instr[30];
  // Bits of a wider instruction word beyond the RV32I fields are ignored.
  assign w_unused = &{1'b0, Instr};

  assign ALUControl = ALUCTL_W'(w_alu);

  // Immediate format is a pure function of the opcode, independent of state.
  always_comb begin
    w_imm_src = 3'b000;
    case (w_opcode)
      c_op_store:           w_imm_src = 3'b001;
      c_op_branch:          w_imm_src = 3'b010;
      c_op_jal:             w_imm_src = 3'b011;
      c_op_lui, c_op_auipc: w_imm_src = 3'b100;
      default:              w_imm_src = 3'b000;
    endcase
  end

  // ALU operation for R/I execute; subtract only for R-type with bit 30 set,
  // while bit 30 selects sra over srl for both R and I forms.
  always_comb begin
    w_alu_op = 4'd0;
    case (w_funct3)
      3'b000:  w_alu_op = (r_state == S_EXECR && w_bit30) ? 4'd1 : 4'd0;
      3'b001:  w_alu_op = 4'd7;
      3'b010:  w_alu_op = 4'd5;
      3'b011:  w_alu_op = 4'd6;
      3'b100:  w_alu_op = 4'd4;
      3'b101:  w_alu_op = w_bit30 ? 4'd9 : 4'd8;
      3'b110:  w_alu_op = 4'd3;
      default: w_alu_op = 4'd2;
    endcase
  end

  // Branch condition from the flags of rs1 - rs2; Carry=1 means no borrow.
  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = Negative ^ Overflow;
      3'b101:  w_taken = ~(Negative ^ Overflow);
      3'b110:  w_taken = ~Carry;
      3'b111:  w_taken = Carry;
      default: w_taken = 1'b0;
    endcase
  end

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next state and all outputs; everything is forced low while reset is held.
  always_comb begin
    w_next       = r_state;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ImmSrc       = 3'b000;
    w_alu        = 4'd0;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;
    if (reset_n) begin
      ImmSrc = w_imm_src;
      case (r_state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ResultSrc = 2'b10;
          ALUSrcB   = 2'b10;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (w_opcode)
            c_op_load, c_op_store: w_next = S_MEMADR;
            c_op_rtype:            w_next = S_EXECR;
            c_op_itype:            w_next = S_EXECI;
            c_op_branch:           w_next = S_BRANCH;
            c_op_jal:              w_next = S_JAL;
            c_op_jalr:             w_next = S_JALR;
            c_op_lui:              w_next = S_LUI;
            c_op_auipc:            w_next = S_AUIPC;
            default: begin
`ifdef RISC_ILLEGAL_TRAP_EN
              w_next = S_TRAP;
`else
              InstrDone = 1'b1;
              w_next    = S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          w_next  = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
          if (MemReady) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          w_next    = S_FETCH;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (MemReady) begin
            InstrDone = 1'b1;
            w_next    = S_FETCH;
          end
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b00;
          w_alu   = w_alu_op;
          w_next  = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          w_alu   = w_alu_op;
          w_next  = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          w_next    = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA   = 2'b10;
          w_alu     = 4'd1;
          PCWrite   = w_taken;
          InstrDone = 1'b1;
          w_next    = S_FETCH;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
          w_next  = S_ALUWB;
        end
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
          w_next    = S_JLINK;
        end
        S_JLINK: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          w_next  = S_ALUWB;
        end
        S_LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
          w_next  = S_ALUWB;
        end
        S_AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          w_next  = S_ALUWB;
        end
`ifdef RISC_ILLEGAL_TRAP_EN
        S_TRAP: begin
          IllegalInstr = 1'b1;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_riscv_multicycle_controller                           |
// | Description : Cycle-by-cycle scoreboard bench for the multi-cycle     |
// |               controller; expected control vectors are queued as     |
// |               stimulus is driven and compared on the falling edge.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_riscv_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] Instr;
  logic        Zero, Negative, Carry, Overflow, MemReady;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        InstrDone, IllegalInstr;

  riscv_multicycle_controller #(.W(32), .ALUCTL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .Instr(Instr),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .InstrDone(InstrDone),
    .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [20:0] v;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t r_pop;

  logic [31:0] cur_instr;
  logic [3:0]  cur_flags;  // {Z, N, C, V}

  logic [20:0] w_obs;
  assign w_obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
                  InstrDone, IllegalInstr};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pack: MemReq MemWrite AdrSrc IRWrite PCWrite RegWrite ResultSrc A B Imm ALU Done Ill
  function automatic logic [20:0] ov(input bit mrq, input bit mw, input bit ad,
      input bit ir, input bit pw, input bit rw, input logic [1:0] rs,
      input logic [1:0] a, input logic [1:0] b, input logic [2:0] im,
      input logic [3:0] al, input bit dn, input bit il);
    return {mrq, mw, ad, ir, pw, rw, rs, a, b, im, al, dn, il};
  endfunction

  function automatic logic [20:0] fetch_v(input bit rdy, input logic [2:0] im);
    return ov(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, im, 4'd0, 0, 0);
  endfunction

  function automatic logic [20:0] decode_v(input logic [2:0] im, input bit dn);
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 4'd0, dn, 0);
  endfunction

  function automatic logic [20:0] aluwb_v(input logic [2:0] im);
    return ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'd0, 1, 0);
  endfunction

  // One clock cycle: apply inputs just after the rising edge, queue expectation.
  task automatic drive(input logic rn, input logic mr, input logic [20:0] e, input string t);
    exp_t x;
    @(posedge clk);
    #1;
    reset_n  = rn;
    MemReady = mr;
    Instr    = cur_instr;
    {Zero, Negative, Carry, Overflow} = cur_flags;
    x.v   = e;
    x.tag = t;
    sb.push_back(x);
  endtask

  // Compare the oldest expectation against the settled outputs mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      r_pop = sb.pop_front();
      check_eq(r_pop.tag, {11'b0, w_obs}, {11'b0, r_pop.v});
    end
  end

  task automatic run_alu(input logic [31:0] ins, input logic [1:0] b,
                         input logic [3:0] alu, input string t);
    cur_instr = ins;
    drive(1, 1, fetch_v(1, 3'b000), {t, "_fetch"});
    drive(1, 1, decode_v(3'b000, 0), {t, "_decode"});
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, b, 3'b000, alu, 0, 0), {t, "_exec"});
    drive(1, 1, aluwb_v(3'b000), {t, "_aluwb"});
  endtask

  task automatic run_br(input logic [31:0] ins, input logic [3:0] flags,
                        input bit taken, input string t);
    cur_instr = ins;
    cur_flags = flags;
    drive(1, 1, fetch_v(1, 3'b010), {t, "_fetch"});
    drive(1, 1, decode_v(3'b010, 0), {t, "_decode"});
    drive(1, 1, ov(0, 0, 0, 0, taken, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'd1, 1, 0), {t, "_branch"});
    cur_flags = 4'b0000;
  endtask

  task automatic run_u(input logic [31:0] ins, input logic [1:0] a, input string t);
    cur_instr = ins;
    drive(1, 1, fetch_v(1, 3'b100), {t, "_fetch"});
    drive(1, 1, decode_v(3'b100, 0), {t, "_decode"});
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, a, 2'b01, 3'b100, 4'd0, 0, 0), {t, "_exec"});
    drive(1, 1, aluwb_v(3'b100), {t, "_aluwb"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    MemReady  = 1'b0;
    Instr     = 32'h0;
    {Zero, Negative, Carry, Overflow} = 4'b0000;
    cur_instr = 32'h002081B3;
    cur_flags = 4'b0000;

    // Reset holds everything low even though FETCH would request memory.
    drive(0, 1, 21'd0, "reset0");
    drive(0, 1, 21'd0, "reset1");

    // R/I-type ALU decoding.
    run_alu(32'h002081B3, 2'b00, 4'd0, "add");
    run_alu(32'h402081B3, 2'b00, 4'd1, "sub");
    run_alu(32'h0020A1B3, 2'b00, 4'd5, "slt");
    run_alu(32'h4010D193, 2'b01, 4'd9, "srai");
    run_alu(32'h0010D193, 2'b01, 4'd8, "srli");
    run_alu(32'hC0000093, 2'b01, 4'd0, "addi_neg");

    // lw with two wait cycles in FETCH and in MEMREAD: nine cycles.
    cur_instr = 32'h0000A283;
    drive(1, 0, fetch_v(0, 3'b000), "lw_fetch_w0");
    drive(1, 0, fetch_v(0, 3'b000), "lw_fetch_w1");
    drive(1, 1, fetch_v(1, 3'b000), "lw_fetch");
    drive(1, 1, decode_v(3'b000, 0), "lw_decode");
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 0, 0), "lw_memadr");
    drive(1, 0, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 0), "lw_memrd_w0");
    drive(1, 0, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 0), "lw_memrd_w1");
    drive(1, 1, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 0), "lw_memrd");
    drive(1, 1, ov(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0, 1, 0), "lw_memwb");

    // sw with one wait cycle on the store.
    cur_instr = 32'h0020A223;
    drive(1, 1, fetch_v(1, 3'b001), "sw_fetch");
    drive(1, 1, decode_v(3'b001, 0), "sw_decode");
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0), "sw_memadr");
    drive(1, 0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0), "sw_memwr_w0");
    drive(1, 1, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 1, 0), "sw_memwr");

    // Branch conditions; flags are {Z, N, C, V}.
    run_br(32'h0020C063, 4'b0100, 1, "blt_n1v0");
    run_br(32'h0020C063, 4'b0101, 0, "blt_n1v1");
    run_br(32'h0020D063, 4'b0101, 1, "bge_n1v1");
    run_br(32'h0020F063, 4'b0000, 0, "bgeu_c0");
    run_br(32'h0020F063, 4'b0010, 1, "bgeu_c1");
    run_br(32'h0020E063, 4'b0000, 1, "bltu_c0");
    run_br(32'h00208063, 4'b1000, 1, "beq_z1");
    run_br(32'h00209063, 4'b1000, 0, "bne_z1");
    run_br(32'h0020A063, 4'b1111, 0, "f3_010");

    // jal: target in JAL, link written in ALUWB.
    cur_instr = 32'h000000EF;
    drive(1, 1, fetch_v(1, 3'b011), "jal_fetch");
    drive(1, 1, decode_v(3'b011, 0), "jal_decode");
    drive(1, 1, ov(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'd0, 0, 0), "jal_jal");
    drive(1, 1, aluwb_v(3'b011), "jal_aluwb");

    // jalr: five cycles.
    cur_instr = 32'h000100E7;
    drive(1, 1, fetch_v(1, 3'b000), "jalr_fetch");
    drive(1, 1, decode_v(3'b000, 0), "jalr_decode");
    drive(1, 1, ov(0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 3'b000, 4'd0, 0, 0), "jalr_jalr");
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0, 0, 0), "jalr_jlink");
    drive(1, 1, aluwb_v(3'b000), "jalr_aluwb");

    run_u(32'h123452B7, 2'b11, "lui");
    run_u(32'h12345297, 2'b01, "auipc");

    // Reset asserted while a store waits: request drops in the same cycle.
    cur_instr = 32'h0020A223;
    drive(1, 1, fetch_v(1, 3'b001), "rst_sw_fetch");
    drive(1, 1, decode_v(3'b001, 0), "rst_sw_decode");
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0), "rst_sw_memadr");
    drive(1, 0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0), "rst_sw_memwr_w0");
    drive(0, 0, 21'd0, "rst_sw_drop");
    drive(0, 1, 21'd0, "rst_sw_hold");
    drive(1, 0, fetch_v(0, 3'b001), "rst_sw_refetch");
    drive(1, 1, fetch_v(1, 3'b001), "rst_sw_fetch2");
    drive(1, 1, decode_v(3'b001, 0), "rst_sw_decode2");

    // Illegal opcode 0000000 (rst_sw_decode2 leads into a fresh MEMADR/MEMWRITE first).
    drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0), "rst_sw_memadr2");
    drive(1, 1, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 1, 0), "rst_sw_memwr2");
    cur_instr = 32'h00000000;
    drive(1, 1, fetch_v(1, 3'b000), "ill_fetch");
`ifdef RISC_ILLEGAL_TRAP_EN
    drive(1, 1, decode_v(3'b000, 0), "ill_decode");
    for (int i = 0; i < 20; i++)
      drive(1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 1), "ill_trap");
    drive(0, 1, 21'd0, "ill_reset");
    drive(1, 1, fetch_v(1, 3'b000), "ill_refetch");
`else
    drive(1, 1, decode_v(3'b000, 1), "ill_decode_nop");
    drive(1, 0, fetch_v(0, 3'b000), "ill_refetch");
`endif

    @(negedge clk);
    #1;
    check_eq("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
